// File: rtl/ctrl_pkg.sv
// Shared opcodes, control encodings, sequencer state and the E-stage control bundle
// for the pipelined RV32I(+M) controller.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] RES_ALU   = 3'd0;
  localparam logic [2:0] RES_MEM   = 3'd1;
  localparam logic [2:0] RES_PC4   = 3'd2;
  localparam logic [2:0] RES_IMM   = 3'd3;
  localparam logic [2:0] RES_AUIPC = 3'd4;
  localparam logic [2:0] RES_MD    = 3'd5;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  // Load and store selects are one-hot so the LSU can steer byte lanes directly.
  localparam logic [4:0] LD_B  = 5'b00001;
  localparam logic [4:0] LD_H  = 5'b00010;
  localparam logic [4:0] LD_W  = 5'b00100;
  localparam logic [4:0] LD_BU = 5'b01000;
  localparam logic [4:0] LD_HU = 5'b10000;
  localparam logic [2:0] ST_B  = 3'b001;
  localparam logic [2:0] ST_H  = 3'b010;
  localparam logic [2:0] ST_W  = 3'b100;

  typedef enum logic [0:0] {SEQ_IDLE = 1'b0, SEQ_RUN = 1'b1} seq_state_e;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       alusrc;
    logic [2:0] resultsrc;
    logic [3:0] alucontrol;
    logic [4:0] load_src;
    logic [2:0] store_src;
    logic       jal;
    logic       jalr;
    logic       branch;
    logic       illegal;
    logic [2:0] md_op;
    logic       md_valid;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational D-stage decoder: instr_d -> control bundle and immediate select.
// RV_M_EXT_EN enables decoding of RV32M (funct7=0000001) ops; otherwise they are illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr_d,
  input  logic         valid_d,
  output logic [2:0]   immsrc_d,
  output ctrl_bundle_t ctrl_d
);
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic         known;
  logic         unused_instr_bits;
  ctrl_bundle_t dec;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[31:25];
  assign unused_instr_bits = ^{instr_d[24:15], instr_d[11:7]};

  always_comb begin
    dec      = CTRL_BUBBLE;
    known    = 1'b1;
    immsrc_d = IMM_I;
    case (opcode)
      OP_LOAD: begin
        dec.regwrite  = 1'b1;
        dec.alusrc    = 1'b1;
        dec.resultsrc = RES_MEM;
        case (funct3)
          3'b000:  dec.load_src = LD_B;
          3'b001:  dec.load_src = LD_H;
          3'b010:  dec.load_src = LD_W;
          3'b100:  dec.load_src = LD_BU;
          3'b101:  dec.load_src = LD_HU;
          default: known = 1'b0;
        endcase
      end
      OP_STORE: begin
        immsrc_d     = IMM_S;
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        case (funct3)
          3'b000:  dec.store_src = ST_B;
          3'b001:  dec.store_src = ST_H;
          3'b010:  dec.store_src = ST_W;
          default: known = 1'b0;
        endcase
      end
      OP_IMM: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        case (funct3)
          3'b000:  dec.alucontrol = ALU_ADD;
          3'b001:  dec.alucontrol = ALU_SLL;
          3'b010:  dec.alucontrol = ALU_SLT;
          3'b011:  dec.alucontrol = ALU_SLTU;
          3'b100:  dec.alucontrol = ALU_XOR;
          3'b101:  dec.alucontrol = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alucontrol = ALU_OR;
          default: dec.alucontrol = ALU_AND;
        endcase
        // Only the shift-immediate forms constrain funct7; elsewhere it is immediate data.
        if (funct3 == 3'b001)      known = (funct7 == F7_BASE);
        else if (funct3 == 3'b101) known = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      end
      OP_OP: begin
        dec.regwrite = 1'b1;
        if (funct7 == F7_MULDIV) begin
`ifdef RV_M_EXT_EN
          dec.md_valid  = 1'b1;
          dec.md_op     = funct3;
          dec.resultsrc = RES_MD;
`else
          known = 1'b0;
`endif
        end else begin
          known = (funct7 == F7_BASE) ||
                  ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
          case (funct3)
            3'b000:  dec.alucontrol = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  dec.alucontrol = ALU_SLL;
            3'b010:  dec.alucontrol = ALU_SLT;
            3'b011:  dec.alucontrol = ALU_SLTU;
            3'b100:  dec.alucontrol = ALU_XOR;
            3'b101:  dec.alucontrol = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  dec.alucontrol = ALU_OR;
            default: dec.alucontrol = ALU_AND;
          endcase
        end
      end
      OP_BRANCH: begin
        immsrc_d       = IMM_B;
        dec.branch     = 1'b1;
        dec.alucontrol = ALU_SUB;
        known          = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OP_JAL: begin
        immsrc_d      = IMM_J;
        dec.regwrite  = 1'b1;
        dec.jal       = 1'b1;
        dec.resultsrc = RES_PC4;
      end
      OP_JALR: begin
        dec.regwrite  = 1'b1;
        dec.alusrc    = 1'b1;
        dec.jalr      = 1'b1;
        dec.resultsrc = RES_PC4;
        known         = (funct3 == 3'b000);
      end
      OP_LUI: begin
        immsrc_d      = IMM_U;
        dec.regwrite  = 1'b1;
        dec.resultsrc = RES_IMM;
      end
      OP_AUIPC: begin
        immsrc_d      = IMM_U;
        dec.regwrite  = 1'b1;
        dec.resultsrc = RES_AUIPC;
      end
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_d = CTRL_BUBBLE;
    if (valid_d) begin
      if (known) ctrl_d = dec;
      else       ctrl_d.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: E-stage control register, jump/branch redirect and M-op latency sequencer.
// Define RV_M_EXT_EN to decode RV32M ops and build the sequencer; otherwise md_* and stall_fd are 0.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        flush_e,
  input  logic        branch_taken_e,
  output logic [2:0]  immsrc_d,
  output logic        regwrite_e,
  output logic        memwrite_e,
  output logic        alusrc_e,
  output logic [2:0]  resultsrc_e,
  output logic [3:0]  alucontrol_e,
  output logic [4:0]  load_src_e,
  output logic [2:0]  store_src_e,
  output logic        jal_e,
  output logic        jalr_e,
  output logic        branch_e,
  output logic        illegal_e,
  output logic [2:0]  md_op_e,
  output logic        md_valid_e,
  output logic        md_start,
  output logic        md_done,
  output logic [1:0]  pcsrc,
  output logic        kill_d,
  output logic        stall_fd
);
  ctrl_bundle_t ctrl_d, e_q, e_d;

  ctrl_decode u_decode (
    .instr_d  (instr_d),
    .valid_d  (valid_d),
    .immsrc_d (immsrc_d),
    .ctrl_d   (ctrl_d)
  );

  // The decoder already yields a bubble for valid_d=0.
  always_comb begin
    e_d = e_q;
    if (!stall_fd) begin
      if (flush_e || kill_d) e_d = CTRL_BUBBLE;
      else                   e_d = ctrl_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) e_q <= CTRL_BUBBLE;
    else     e_q <= e_d;
  end

  assign regwrite_e   = e_q.regwrite;
  assign memwrite_e   = e_q.memwrite;
  assign alusrc_e     = e_q.alusrc;
  assign resultsrc_e  = e_q.resultsrc;
  assign alucontrol_e = e_q.alucontrol;
  assign load_src_e   = e_q.load_src;
  assign store_src_e  = e_q.store_src;
  assign jal_e        = e_q.jal;
  assign jalr_e       = e_q.jalr;
  assign branch_e     = e_q.branch;
  assign illegal_e    = e_q.illegal;
  assign md_op_e      = e_q.md_op;
  assign md_valid_e   = e_q.md_valid;

  always_comb begin
    pcsrc = 2'b00;
    if (e_q.jalr)                                 pcsrc = 2'b10;
    else if (e_q.jal || (e_q.branch && branch_taken_e)) pcsrc = 2'b01;
  end
  assign kill_d = (pcsrc != 2'b00);

`ifdef RV_M_EXT_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat, lat_last;

  assign lat      = e_q.md_op[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
  assign lat_last = lat - CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_start = 1'b0;
    md_done  = 1'b0;
    stall_fd = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (e_q.md_valid) begin
          md_start = 1'b1;
          if (lat == CNT_W'(1)) begin
            md_done = 1'b1;
          end else begin
            stall_fd = 1'b1;
            state_d  = SEQ_RUN;
            cnt_d    = CNT_W'(1);
          end
        end
      end
      SEQ_RUN: begin
        if (cnt_q < lat_last) begin
          stall_fd = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          md_done = 1'b1;
          state_d = SEQ_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  localparam int unused_lat = MUL_LAT + DIV_LAT;
  assign md_start = 1'b0;
  assign md_done  = 1'b0;
  assign stall_fd = 1'b0;
`endif

endmodule
